mmio_bridge: RTL and testbench

MMIO_BRIDGE -- requirements
Module: mmio_bridge

---
 rtl/bridge_pkg.sv | 13 +
 rtl/addr_decoder.sv | 24 ++
 rtl/mmio_bridge.sv | 144 ++++++++++++++
 tb/tb_mmio_bridge.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/bridge_pkg.sv
// Shared constants for the MMIO bridge: FSM encoding and default decode map.
package bridge_pkg;

    // FSM state encoding; IDLE must stay 0 so the reset value reads as idle.
    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_ACCESS = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    // Default three-device map: 16 KiB window at 0, two 16-byte windows at 0x7F00/0x7F10.
    localparam logic [95:0] DEFAULT_DEV_BASE = {32'h0000_7F10, 32'h0000_7F00, 32'h0000_0000};
    localparam logic [95:0] DEFAULT_DEV_MASK = {32'hFFFF_FFF0, 32'hFFFF_FFF0, 32'hFFFF_C000};

endpackage

// File: rtl/addr_decoder.sv
// Combinational address decoder: one-hot select of the lowest-index matching window.
module addr_decoder #(
    parameter int                    NUM_DEV  = 3,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE = bridge_pkg::DEFAULT_DEV_BASE,
    parameter logic [NUM_DEV*32-1:0] DEV_MASK = bridge_pkg::DEFAULT_DEV_MASK
) (
    input  logic [31:0]        addr,
    output logic [NUM_DEV-1:0] hitOneHot,
    output logic               anyHit
);

    // Priority decode: once a window has claimed the address, higher indices are ignored.
    always_comb begin
        hitOneHot = '0;
        anyHit    = 1'b0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (!anyHit && ((addr & DEV_MASK[i*32 +: 32]) == DEV_BASE[i*32 +: 32])) begin
                hitOneHot[i] = 1'b1;
                anyHit       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mmio_bridge.sv
// CPU-to-device MMIO bridge: decodes one request at a time, waits for the selected
// device (bounded by TIMEOUT), and returns a one-cycle response strobe.
//
// Handshake: a request transfers on a rising edge where cpuReqValid && cpuReqReady;
// cpuReqReady is high only while idle. There is no response back-pressure: the CPU
// must take cpuRdata/cpuErr in the cycle cpuRespValid is high (they hold afterwards).
module mmio_bridge
    import bridge_pkg::*;
#(
    parameter int                    NUM_DEV  = 3,
    parameter logic [NUM_DEV*32-1:0] DEV_BASE = DEFAULT_DEV_BASE,
    parameter logic [NUM_DEV*32-1:0] DEV_MASK = DEFAULT_DEV_MASK,
    parameter int                    TIMEOUT  = 15
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    cpuReqValid,
    output logic                    cpuReqReady,
    input  logic                    cpuWe,
    input  logic [31:0]             cpuAddr,
    input  logic [31:0]             cpuWdata,
    input  logic [3:0]              cpuByteEn,
    output logic                    cpuRespValid,
    output logic [31:0]             cpuRdata,
    output logic                    cpuErr,
    output logic [NUM_DEV-1:0]      devSel,
    output logic                    devWe,
    output logic [31:0]             devAddr,
    output logic [31:0]             devWdata,
    output logic [3:0]              devByteEn,
    input  logic [32*NUM_DEV-1:0]   devRdata,
    input  logic [NUM_DEV-1:0]      devReady,
    input  logic [NUM_DEV-1:0]      devIrq,
    output logic [NUM_DEV-1:0]      hwInt,
    output logic [1:0]              dbgState
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);

    logic [1:0]         state;
    logic [CNT_W-1:0]   waitCnt;
    logic [NUM_DEV-1:0] selLatched;
    logic               weLatched;
    logic [NUM_DEV-1:0] hitOneHot;
    logic               anyHit;
    logic               selReady;
    logic [31:0]        selRdata;

    addr_decoder #(
        .NUM_DEV  (NUM_DEV),
        .DEV_BASE (DEV_BASE),
        .DEV_MASK (DEV_MASK)
    ) uDecoder (
        .addr      (cpuAddr),
        .hitOneHot (hitOneHot),
        .anyHit    (anyHit)
    );

    // Pick the ready flag and read data of the latched device only.
    always_comb begin
        selRdata = '0;
        for (int i = 0; i < NUM_DEV; i++) begin
            if (selLatched[i]) begin
                selRdata = selRdata | devRdata[i*32 +: 32];
            end
        end
    end

    assign selReady = |(devReady & selLatched);

    // Outputs decoded from state so they drop immediately with an asynchronous reset.
    assign cpuReqReady  = (state == ST_IDLE);
    assign cpuRespValid = (state == ST_RESP);
    assign devSel       = (state == ST_ACCESS) ? selLatched : '0;
    assign devWe        = (state == ST_ACCESS) && weLatched;
    assign dbgState     = state;

    // Transaction FSM with request latch, bounded wait counter and response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= ST_IDLE;
            waitCnt    <= '0;
            selLatched <= '0;
            weLatched  <= 1'b0;
            devAddr    <= '0;
            devWdata   <= '0;
            devByteEn  <= '0;
            cpuRdata   <= '0;
            cpuErr     <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (cpuReqValid) begin
                        devAddr    <= cpuAddr;
                        weLatched  <= cpuWe;
                        devWdata   <= cpuWdata;
                        devByteEn  <= cpuByteEn;
                        selLatched <= hitOneHot;
                        waitCnt    <= '0;
                        if (anyHit) begin
                            state <= ST_ACCESS;
                        end else begin
                            // Unmapped: the write is dropped and the error is reported at once.
                            state    <= ST_RESP;
                            cpuErr   <= 1'b1;
                            cpuRdata <= '0;
                        end
                    end
                end
                ST_ACCESS: begin
                    // Ready is checked first so a ready in the final wait cycle still succeeds.
                    if (selReady) begin
                        cpuRdata <= weLatched ? 32'd0 : selRdata;
                        cpuErr   <= 1'b0;
                        state    <= ST_RESP;
                    end else if (waitCnt == CNT_W'(TIMEOUT - 1)) begin
                        waitCnt  <= waitCnt + 1'b1;
                        cpuRdata <= '0;
                        cpuErr   <= 1'b1;
                        state    <= ST_RESP;
                    end else begin
                        waitCnt <= waitCnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    // Interrupt levels pass through one register stage, independent of the FSM.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            hwInt <= '0;
        end else begin
            hwInt <= devIrq;
        end
    end

endmodule

// File: tb/tb_mmio_bridge.sv
// Directed bench for mmio_bridge with the default three-device map and TIMEOUT=15.
module tb_mmio_bridge;

    logic        clk;
    logic        reset_n;
    logic        cpuReqValid;
    logic        cpuReqReady;
    logic        cpuWe;
    logic [31:0] cpuAddr;
    logic [31:0] cpuWdata;
    logic [3:0]  cpuByteEn;
    logic        cpuRespValid;
    logic [31:0] cpuRdata;
    logic        cpuErr;
    logic [2:0]  devSel;
    logic        devWe;
    logic [31:0] devAddr;
    logic [31:0] devWdata;
    logic [3:0]  devByteEn;
    logic [95:0] devRdata;
    logic [2:0]  devReady;
    logic [2:0]  devIrq;
    logic [2:0]  hwInt;
    logic [1:0]  dbgState;

    int nChecks = 0;
    int nErrors = 0;
    logic [31:0] exp_q[$];

    mmio_bridge dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .cpuReqValid  (cpuReqValid),
        .cpuReqReady  (cpuReqReady),
        .cpuWe        (cpuWe),
        .cpuAddr      (cpuAddr),
        .cpuWdata     (cpuWdata),
        .cpuByteEn    (cpuByteEn),
        .cpuRespValid (cpuRespValid),
        .cpuRdata     (cpuRdata),
        .cpuErr       (cpuErr),
        .devSel       (devSel),
        .devWe        (devWe),
        .devAddr      (devAddr),
        .devWdata     (devWdata),
        .devByteEn    (devByteEn),
        .devRdata     (devRdata),
        .devReady     (devReady),
        .devIrq       (devIrq),
        .hwInt        (hwInt),
        .dbgState     (dbgState)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // One full transaction. readyAt = index of the ACCESS cycle (0-based) in which the
    // device raises ready, or -1 for never. All sampling and driving at the falling edge.
    task automatic runTxn(input string tag, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] be, input int readyAt,
                          input int dev, input logic [31:0] expRdata, input logic expErr,
                          input int expAccess, input logic [2:0] expSel);
        int  accessCycles;
        bit  gotResp;
        logic [31:0] expData;
        accessCycles = 0;
        gotResp      = 0;
        exp_q.push_back(expRdata);
        @(negedge clk);
        chk({tag, "_reqReady"}, 32'(cpuReqReady), 32'd1);
        cpuReqValid = 1'b1;
        cpuWe       = we;
        cpuAddr     = addr;
        cpuWdata    = wdata;
        cpuByteEn   = be;
        devReady    = 3'b000;
        @(negedge clk);
        cpuReqValid = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (cpuRespValid) begin
                gotResp = 1;
                break;
            end
            accessCycles++;
            chk({tag, "_devSel"}, 32'(devSel), 32'(expSel));
            chk({tag, "_devWe"}, 32'(devWe), 32'(we));
            if (accessCycles == 1) begin
                chk({tag, "_devAddr"}, devAddr, addr);
                chk({tag, "_devWdata"}, devWdata, wdata);
                chk({tag, "_devByteEn"}, 32'(devByteEn), 32'(be));
            end
            devReady = (accessCycles - 1 == readyAt) ? (3'b001 << dev) : 3'b000;
            @(negedge clk);
        end
        devReady = 3'b000;
        chk({tag, "_gotResp"}, 32'(gotResp), 32'd1);
        chk({tag, "_accessCycles"}, 32'(accessCycles), 32'(expAccess));
        expData = exp_q.pop_front();
        chk({tag, "_rdata"}, cpuRdata, expData);
        chk({tag, "_err"}, 32'(cpuErr), 32'(expErr));
        chk({tag, "_selOffInResp"}, 32'(devSel), 32'd0);
        chk({tag, "_reqReadyInResp"}, 32'(cpuReqReady), 32'd0);
        @(negedge clk);
        chk({tag, "_respOneCycle"}, 32'(cpuRespValid), 32'd0);
        chk({tag, "_reqReadyAfter"}, 32'(cpuReqReady), 32'd1);
        chk({tag, "_rdataHeld"}, cpuRdata, expData);
        chk({tag, "_errHeld"}, 32'(cpuErr), 32'(expErr));
    endtask

    initial begin
        reset_n     = 1'b0;
        cpuReqValid = 1'b0;
        cpuWe       = 1'b0;
        cpuAddr     = '0;
        cpuWdata    = '0;
        cpuByteEn   = '0;
        devRdata    = {32'hCAFE_0002, 32'h1111_2222, 32'hDEAD_BEEF};
        devReady    = '0;
        devIrq      = '0;

        // Values while reset is held
        #2;
        chk("rst_reqReady", 32'(cpuReqReady), 32'd1);
        chk("rst_respValid", 32'(cpuRespValid), 32'd0);
        chk("rst_devSel", 32'(devSel), 32'd0);
        chk("rst_rdata", cpuRdata, 32'd0);
        chk("rst_err", 32'(cpuErr), 32'd0);
        chk("rst_hwInt", 32'(hwInt), 32'd0);
        chk("rst_devAddr", devAddr, 32'd0);
        chk("rst_state", 32'(dbgState), 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;

        // Zero-wait read from device 0
        runTxn("rd_dev0", 1'b0, 32'h0000_1000, 32'd0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1, 3'b001);
        // Write to device 1, ready after three wait cycles
        runTxn("wr_dev1", 1'b1, 32'h0000_7F04, 32'h5, 4'hF, 3, 1, 32'd0, 1'b0, 4, 3'b010);
        // Unmapped addresses, including just past device 0's window
        runTxn("unmapped", 1'b0, 32'h0000_9000, 32'd0, 4'h0, 0, 0, 32'd0, 1'b1, 0, 3'b000);
        runTxn("unmapped_4000", 1'b1, 32'h0000_4000, 32'h77, 4'h3, 0, 0, 32'd0, 1'b1, 0, 3'b000);
        // Top byte of device 0's window
        runTxn("rd_dev0_top", 1'b0, 32'h0000_3FFF, 32'd0, 4'h0, 1, 0, 32'hDEAD_BEEF, 1'b0, 2, 3'b001);
        // Device 2 never ready: fifteen ACCESS cycles then timeout
        runTxn("timeout", 1'b0, 32'h0000_7F14, 32'd0, 4'h0, -1, 2, 32'd0, 1'b1, 15, 3'b100);
        // Ready in the last allowed cycle wins over the timeout
        runTxn("ready_at_limit", 1'b0, 32'h0000_7F14, 32'd0, 4'h0, 14, 2, 32'hCAFE_0002, 1'b0, 15, 3'b100);

        // Interrupt register, with a transaction in flight
        fork
            runTxn("rd_dev1_irq", 1'b0, 32'h0000_7F08, 32'd0, 4'h0, 2, 1, 32'h1111_2222, 1'b0, 3, 3'b010);
            begin
                @(negedge clk);
                @(negedge clk);
                devIrq = 3'b101;
                #1;
                chk("irq_notYet", 32'(hwInt), 32'd0);
                @(negedge clk);
                chk("irq_101", 32'(hwInt), 32'b101);
                devIrq = 3'b010;
                @(negedge clk);
                chk("irq_010", 32'(hwInt), 32'b010);
                devIrq = 3'b000;
                @(negedge clk);
                chk("irq_clear", 32'(hwInt), 32'd0);
            end
        join

        // Reset in the middle of an ACCESS wait
        @(negedge clk);
        cpuReqValid = 1'b1;
        cpuWe       = 1'b0;
        cpuAddr     = 32'h0000_7F14;
        @(negedge clk);
        cpuReqValid = 1'b0;
        chk("abort_inAccess", 32'(devSel), 32'b100);
        repeat (2) @(negedge clk);
        reset_n = 1'b0;
        #1;
        chk("abort_devSel", 32'(devSel), 32'd0);
        chk("abort_respValid", 32'(cpuRespValid), 32'd0);
        chk("abort_reqReady", 32'(cpuReqReady), 32'd1);
        chk("abort_state", 32'(dbgState), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk("abort_noResp", 32'(cpuRespValid), 32'd0);
            chk("abort_idle", 32'(cpuReqReady), 32'd1);
        end
        // Bridge still works after the abort
        runTxn("post_abort", 1'b0, 32'h0000_0004, 32'd0, 4'h0, 0, 0, 32'hDEAD_BEEF, 1'b0, 1, 3'b001);

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end

endmodule
